hyperthermia_monitor_n: RTL and testbench
=========================================

Name: hyperthermia_monitor_n

Overview:
- Parametrised multi-zone successor to the single-cabin hyperthermia controller.
- Periodically samples N_ZONES temperature/presence channels plus one shared ignition input.
- Per zone: applies a persistence filter to the alarm and hysteresis to the ventilation, latches alarms until acknowledged, and reports the hottest occupied zone for the 7-segment display path.
- Sits between the input pins and the display/output drivers, replacing the separate input-register / logic / output-register chain.

Parameters:
- N_ZONES, 4, number of monitored zones (1..8).
- TEMP_W, 5, temperature width in unsigned whole degrees.
- SAMPLE_DIV, 16, clock cycles between sample strobes (>= N_ZONES+3).
- PERSIST, 3, consecutive over-threshold samples required to raise an alarm (1..15).
- HYST, 2, ventilation hysteresis in degrees.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- active  in  1  system enable; 0 forces IDLE.
- temp_in  in  N_ZONES*TEMP_W  zone temperatures; zone k in bits [k*TEMP_W +: TEMP_W].
- pres_in  in  N_ZONES  occupant presence per zone.
- car_in  in  1  ignition on.
- th_vent  in  TEMP_W  ventilation threshold.
- th_alarm  in  TEMP_W  alarm threshold.
- ack  in  1  alarm acknowledge pulse.
- vent  out  N_ZONES  ventilation request per zone.
- alarm  out  N_ZONES  latched alarm per zone.
- alarm_any  out  1  OR of alarm.
- worst_zone  out  3  index of the hottest occupied zone.
- worst_temp  out  TEMP_W  temperature of that zone.
- worst_valid  out  1  at least one zone is occupied.
- sample_tick  out  1  one-cycle pulse when the UPDATE state completes.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; persistence counters 0; divider 0; FSM in IDLE.
- FSM states:
  - IDLE: entered whenever active=0 (from any state, next cycle). Clears the divider and persistence counters. Holds alarm and vent values.
  - WAIT: counts the divider 0..SAMPLE_DIV-1. At the terminal count, goes to SAMPLE.
  - SAMPLE: registers temp_in, pres_in and car_in (1 cycle) into snapshot registers. All evaluation uses the snapshot only.
  - EVAL: scans zones 0..N_ZONES-1, one zone per cycle (N_ZONES cycles).
  - UPDATE: registers the new vent/alarm/worst values and pulses sample_tick, then goes to WAIT.
- Sample period: SAMPLE_DIV+N_ZONES+2 cycles. Outputs change only in the cycle after UPDATE.
- Per-zone ventilation (hysteresis):
  - Set when P && T >= th_vent.
  - Cleared when !P, or T < th_vent-HYST (saturating subtraction, floor 0).
  - Otherwise holds its previous value.
- Per-zone persistence counter: increments, saturating at PERSIST, when P && !C && T >= th_alarm. Otherwise it resets to 0.
- Alarm set: when the counter reaches PERSIST, the alarm bit sets.
- Alarm clear: the alarm bit clears only when both hold:
  - ack has been seen since the last UPDATE (captured into a sticky ack_pend flag, cleared in UPDATE);
  - the zone's counter is 0 at this UPDATE.
- ack with the condition still present: the alarm stays set and ack_pend is consumed.
- Ignition on (C=1): suppresses new alarm counting (counters reset). Does not clear already-latched alarms. Ventilation unaffected.
- Worst zone:
  - Highest T among zones with P=1; ties go to the lowest index.
  - No occupied zone: worst_valid=0, worst_zone=0, worst_temp=0.
- Comparisons are unsigned, TEMP_W bits. th_vent=0 means always vent when occupied.
- active falling mid-EVAL: the partial scan is discarded and outputs are not updated.
- ack and UPDATE in the same cycle: the ack applies to that UPDATE.

Decomposition:
- Shared package: FSM state encoding (IDLE, WAIT, SAMPLE, EVAL, UPDATE), default parameter constants, zone-index width function.
- One sub-module, zone_filter: per-zone persistence counter, hysteresis and alarm latch.
  - Inputs: T, P, C, thresholds, eval_en, ack_pend.
  - Outputs: vent, alarm.
  - Instantiated N_ZONES times via generate.
- The scan, worst-zone tracker and divider stay in the top module.

Test Plan:
- Reset/idle: rst=0 then release with active=0 -> all outputs 0, sample_tick never pulses over 100 cycles.
- Vent hysteresis: zone0 P=1, th_vent=20, HYST=2; T 21→19→17 -> vent=1, stays 1 at 19, clears at 17 after the next sample_tick.
- Persistence: zone2 P=1, C=0, th_alarm=25, T=26 -> alarm[2] rises on the 3rd sample_tick (PERSIST=3), not earlier. Dropping T to 24 after 2 samples -> no alarm.
- Ack rules: alarm[2] latched, ack with T still 26 -> alarm stays 1. T=20, then ack -> alarm[2]=0 at the next sample_tick.
- Ignition: C=1 with T=30, P=1 -> no alarm after 10 samples; vent=1.
- Worst zone: temps {22,30,30,35}, pres {1,1,1,0} -> worst_zone=1, worst_temp=30, worst_valid=1. pres all 0 -> worst_valid=0.

Source files
------------

// File: rtl/hyperthermia_monitor_n_pkg.sv
// Shared definitions for the multi-zone hyperthermia monitor: FSM encoding,
// default parameter values and the zone-index width helper.
package hyperthermia_monitor_n_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_EVAL   = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;

  localparam int DEF_N_ZONES    = 4;
  localparam int DEF_TEMP_W     = 5;
  localparam int DEF_SAMPLE_DIV = 16;
  localparam int DEF_PERSIST    = 3;
  localparam int DEF_HYST       = 2;

  function automatic int zone_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hyperthermia_monitor_n_zone.sv
// Per-zone persistence counter, ventilation hysteresis and alarm latch.
// New values are computed on eval_en and become visible on update_en.
module zone_filter
  import hyperthermia_monitor_n_pkg::*;
#(
  parameter int TEMP_W  = DEF_TEMP_W,
  parameter int PERSIST = DEF_PERSIST,
  parameter int HYST    = DEF_HYST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              eval_en,
  input  logic              update_en,
  input  logic [TEMP_W-1:0] temp,
  input  logic              pres,
  input  logic              car,
  input  logic [TEMP_W-1:0] th_vent,
  input  logic [TEMP_W-1:0] th_alarm,
  input  logic              ack_pend,
  output logic              vent,
  output logic              alarm
);

  logic [3:0]        cnt;
  logic              vent_next;
  logic              vent_calc;
  logic              hot;
  logic [TEMP_W-1:0] vent_low;

  // Clear point saturates at zero so a tiny threshold never wraps around.
  always_comb begin
    vent_low  = (th_vent > TEMP_W'(HYST)) ? (th_vent - TEMP_W'(HYST)) : '0;
    hot       = pres && !car && (temp >= th_alarm);
    vent_calc = vent;
    if (pres && (temp >= th_vent)) begin
      vent_calc = 1'b1;
    end else if (!pres || (temp < vent_low)) begin
      vent_calc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      vent_next <= 1'b0;
      vent      <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (eval_en) begin
        vent_next <= vent_calc;
        if (!hot) begin
          cnt <= '0;
        end else if (cnt != 4'(PERSIST)) begin
          cnt <= cnt + 4'd1;
        end
      end
      // An ack only releases the latch once the zone has cooled off.
      if (update_en) begin
        vent <= vent_next;
        if (cnt == 4'(PERSIST)) begin
          alarm <= 1'b1;
        end else if (ack_pend && (cnt == 4'd0)) begin
          alarm <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hyperthermia_monitor_n.sv
// Multi-zone hyperthermia monitor: periodic snapshot of all zones, a one-zone-
// per-cycle scan through the zone filters, and hottest-occupied-zone tracking.
module hyperthermia_monitor_n
  import hyperthermia_monitor_n_pkg::*;
#(
  parameter int N_ZONES    = DEF_N_ZONES,
  parameter int TEMP_W     = DEF_TEMP_W,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int PERSIST    = DEF_PERSIST,
  parameter int HYST       = DEF_HYST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      active,
  input  logic [N_ZONES*TEMP_W-1:0] temp_in,
  input  logic [N_ZONES-1:0]        pres_in,
  input  logic                      car_in,
  input  logic [TEMP_W-1:0]         th_vent,
  input  logic [TEMP_W-1:0]         th_alarm,
  input  logic                      ack,
  output logic [N_ZONES-1:0]        vent,
  output logic [N_ZONES-1:0]        alarm,
  output logic                      alarm_any,
  output logic [2:0]                worst_zone,
  output logic [TEMP_W-1:0]         worst_temp,
  output logic                      worst_valid,
  output logic                      sample_tick
);

  localparam int IDX_W = zone_idx_w(N_ZONES);
  localparam int DIV_W = $clog2(SAMPLE_DIV + 1);

  logic [2:0]                state;
  logic [2:0]                state_next;
  logic [DIV_W-1:0]          div;
  logic [IDX_W-1:0]          idx;
  logic [N_ZONES*TEMP_W-1:0] snap_temp;
  logic [N_ZONES-1:0]        snap_pres;
  logic                      snap_car;
  logic                      ack_pend;
  logic                      ack_eff;
  logic [TEMP_W-1:0]         scan_temp;
  logic                      scan_pres;
  logic                      best_valid;
  logic [2:0]                best_zone;
  logic [TEMP_W-1:0]         best_temp;

  assign ack_eff   = ack_pend | ack;
  assign scan_temp = snap_temp[int'(idx)*TEMP_W +: TEMP_W];
  assign scan_pres = snap_pres[idx];
  assign alarm_any = |alarm;

  always_comb begin
    state_next = state;
    if (!active) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_next = ST_WAIT;
        ST_WAIT:   if (div == DIV_W'(SAMPLE_DIV - 1)) state_next = ST_SAMPLE;
        ST_SAMPLE: state_next = ST_EVAL;
        ST_EVAL:   if (idx == IDX_W'(N_ZONES - 1)) state_next = ST_UPDATE;
        ST_UPDATE: state_next = ST_WAIT;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      div         <= '0;
      idx         <= '0;
      snap_temp   <= '0;
      snap_pres   <= '0;
      snap_car    <= 1'b0;
      ack_pend    <= 1'b0;
      best_valid  <= 1'b0;
      best_zone   <= '0;
      best_temp   <= '0;
      worst_valid <= 1'b0;
      worst_zone  <= '0;
      worst_temp  <= '0;
      sample_tick <= 1'b0;
    end else begin
      state       <= state_next;
      div         <= (state == ST_WAIT && state_next == ST_WAIT) ? div + 1'b1 : '0;
      idx         <= (state == ST_EVAL) ? idx + 1'b1 : '0;
      ack_pend    <= (state == ST_UPDATE) ? 1'b0 : ack_eff;
      sample_tick <= (state == ST_UPDATE);
      if (state == ST_SAMPLE) begin
        snap_temp  <= temp_in;
        snap_pres  <= pres_in;
        snap_car   <= car_in;
        best_valid <= 1'b0;
        best_zone  <= '0;
        best_temp  <= '0;
      end
      // Strict greater-than keeps the lowest index on ties since the scan ascends.
      if (state == ST_EVAL && scan_pres && (!best_valid || scan_temp > best_temp)) begin
        best_valid <= 1'b1;
        best_zone  <= 3'(idx);
        best_temp  <= scan_temp;
      end
      if (state == ST_UPDATE) begin
        worst_valid <= best_valid;
        worst_zone  <= best_zone;
        worst_temp  <= best_temp;
      end
    end
  end

  for (genvar k = 0; k < N_ZONES; k++) begin : g_zone
    zone_filter #(
      .TEMP_W  (TEMP_W),
      .PERSIST (PERSIST),
      .HYST    (HYST)
    ) u_zone (
      .clk       (clk),
      .rst       (rst),
      .clr       (state == ST_IDLE),
      .eval_en   (state == ST_EVAL && idx == IDX_W'(k)),
      .update_en (state == ST_UPDATE),
      .temp      (snap_temp[k*TEMP_W +: TEMP_W]),
      .pres      (snap_pres[k]),
      .car       (snap_car),
      .th_vent   (th_vent),
      .th_alarm  (th_alarm),
      .ack_pend  (ack_eff),
      .vent      (vent[k]),
      .alarm     (alarm[k])
    );
  end

endmodule

// File: tb/tb_hyperthermia_monitor_n.sv
// Scoreboard bench for hyperthermia_monitor_n: each sample period's expected
// outputs are queued when its inputs are driven and checked at sample_tick.
module tb_hyperthermia_monitor_n;

  localparam int N      = 4;
  localparam int TW     = 5;
  localparam int SD     = 16;
  localparam int PS     = 3;
  localparam int HY     = 2;
  localparam int PERIOD = SD + N + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            active;
  logic [N*TW-1:0] temp_in;
  logic [N-1:0]    pres_in;
  logic            car_in;
  logic [TW-1:0]   th_vent;
  logic [TW-1:0]   th_alarm;
  logic            ack;
  logic [N-1:0]    vent;
  logic [N-1:0]    alarm;
  logic            alarm_any;
  logic [2:0]      worst_zone;
  logic [TW-1:0]   worst_temp;
  logic            worst_valid;
  logic            sample_tick;

  hyperthermia_monitor_n #(
    .N_ZONES(N), .TEMP_W(TW), .SAMPLE_DIV(SD), .PERSIST(PS), .HYST(HY)
  ) dut (
    .clk(clk), .rst(rst), .active(active), .temp_in(temp_in), .pres_in(pres_in),
    .car_in(car_in), .th_vent(th_vent), .th_alarm(th_alarm), .ack(ack),
    .vent(vent), .alarm(alarm), .alarm_any(alarm_any), .worst_zone(worst_zone),
    .worst_temp(worst_temp), .worst_valid(worst_valid), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  typedef struct {
    logic [N-1:0]  vent;
    logic [N-1:0]  alarm;
    logic          any;
    logic [2:0]    wz;
    logic [TW-1:0] wt;
    logic          wv;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  int           last_tick = -1;
  logic [N-1:0] m_vent = '0;
  logic [N-1:0] m_alarm = '0;
  int           m_cnt[N];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [N*TW-1:0] temps(input int t0, input int t1, input int t2, input int t3);
    return {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
  endfunction

  // Drives one sample period's inputs and queues the outputs they should produce.
  task automatic applyStimulus(input logic [N*TW-1:0] t, input logic [N-1:0] p,
                               input logic c, input logic a);
    exp_t e;
    int   tz, low, best;
    @(negedge clk);
    temp_in = t;
    pres_in = p;
    car_in  = c;
    if (a) begin
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
    end
    low  = (int'(th_vent) > HY) ? int'(th_vent) - HY : 0;
    best = -1;
    e.wz = '0;
    e.wt = '0;
    for (int k = 0; k < N; k++) begin
      tz = int'(t[k*TW +: TW]);
      if (p[k] && tz >= int'(th_vent)) m_vent[k] = 1'b1;
      else if (!p[k] || tz < low)     m_vent[k] = 1'b0;
      if (p[k] && !c && tz >= int'(th_alarm)) m_cnt[k] = (m_cnt[k] >= PS) ? PS : m_cnt[k] + 1;
      else                                    m_cnt[k] = 0;
      if (m_cnt[k] == PS)            m_alarm[k] = 1'b1;
      else if (a && m_cnt[k] == 0)   m_alarm[k] = 1'b0;
      if (p[k] && tz > best) begin
        best = tz;
        e.wz = 3'(k);
        e.wt = TW'(tz);
      end
    end
    e.vent  = m_vent;
    e.alarm = m_alarm;
    e.any   = |m_alarm;
    e.wv    = (best >= 0);
    sb.push_back(e);
  endtask

  task automatic waitTick();
    int n = 0;
    while (n < 4 * PERIOD && sample_tick !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    if (sample_tick !== 1'b1) begin
      checkOutput("tick_timeout", 32'd0, 32'd1);
    end else begin
      if (last_tick >= 0) checkOutput("period", cycle - last_tick, PERIOD);
      last_tick = cycle;
    end
  endtask

  task automatic compareSample(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_vent"},  vent,        e.vent);
    checkOutput({tag, "_alarm"}, alarm,       e.alarm);
    checkOutput({tag, "_any"},   alarm_any,   e.any);
    checkOutput({tag, "_wz"},    worst_zone,  e.wz);
    checkOutput({tag, "_wt"},    worst_temp,  e.wt);
    checkOutput({tag, "_wv"},    worst_valid, e.wv);
    @(negedge clk);
    checkOutput({tag, "_tick_width"}, sample_tick, 1'b0);
  endtask

  task automatic runSample(input string tag, input logic [N*TW-1:0] t, input logic [N-1:0] p,
                           input logic c, input logic a);
    applyStimulus(t, p, c, a);
    @(negedge clk);
    waitTick();
    compareSample(tag);
  endtask

  initial begin
    int nt;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    rst      = 1'b0;
    active   = 1'b0;
    temp_in  = '0;
    pres_in  = '0;
    car_in   = 1'b0;
    ack      = 1'b0;
    th_vent  = TW'(20);
    th_alarm = TW'(25);
    repeat (3) @(negedge clk);
    checkOutput("rst_vent", vent, 0);
    checkOutput("rst_alarm", alarm, 0);
    checkOutput("rst_wv", worst_valid, 0);
    checkOutput("rst_tick", sample_tick, 0);
    rst = 1'b1;
    temp_in = temps(30, 30, 30, 30);
    pres_in = '1;
    nt = 0;
    repeat (100) begin
      @(negedge clk);
      if (sample_tick) nt++;
    end
    checkOutput("idle_ticks", nt, 0);
    checkOutput("idle_vent", vent, 0);
    checkOutput("idle_alarm", alarm, 0);
    checkOutput("idle_wt", worst_temp, 0);

    active = 1'b1;
    runSample("hyst21", temps(21, 0, 0, 0), 4'b0001, 1'b0, 1'b0);
    runSample("hyst19", temps(19, 0, 0, 0), 4'b0001, 1'b0, 1'b0);
    runSample("hyst17", temps(17, 0, 0, 0), 4'b0001, 1'b0, 1'b0);

    runSample("pers_a1", temps(0, 0, 26, 0), 4'b0100, 1'b0, 1'b0);
    runSample("pers_a2", temps(0, 0, 26, 0), 4'b0100, 1'b0, 1'b0);
    runSample("pers_drop", temps(0, 0, 24, 0), 4'b0100, 1'b0, 1'b0);
    runSample("pers_b1", temps(0, 0, 26, 0), 4'b0100, 1'b0, 1'b0);
    runSample("pers_b2", temps(0, 0, 26, 0), 4'b0100, 1'b0, 1'b0);
    runSample("pers_b3", temps(0, 0, 26, 0), 4'b0100, 1'b0, 1'b0);

    runSample("ack_hot", temps(0, 0, 26, 0), 4'b0100, 1'b0, 1'b1);
    runSample("cool_noack", temps(0, 0, 20, 0), 4'b0100, 1'b0, 1'b0);
    runSample("cool_ack", temps(0, 0, 20, 0), 4'b0100, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) runSample("ign", temps(0, 0, 30, 0), 4'b0100, 1'b1, 1'b0);

    runSample("worst", temps(22, 30, 30, 35), 4'b0111, 1'b0, 1'b0);
    runSample("worst_none", temps(22, 30, 30, 35), 4'b0000, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      runSample("rand",
                temps($urandom_range(15, 31), $urandom_range(15, 31),
                      $urandom_range(15, 31), $urandom_range(15, 31)),
                N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
